// File: rtl/axi_wr_slave_mem_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : axi_wr_slave_mem_if                                        |
// | Brief    : AXI3 write-channel bundle (AW, W, B) with master/slave     |
// |            views                                                     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface axi_wr_slave_mem_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 4
);
    logic                  awvalid;
    logic                  awready;
    logic [ID_W-1:0]       awid;
    logic [ADDR_W-1:0]     awaddr;
    logic [3:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;

    logic                  wvalid;
    logic                  wready;
    logic                  wlast;
    logic [ID_W-1:0]       wid;
    logic [DATA_W/8-1:0]   wstrb;
    logic [DATA_W-1:0]     wdata;

    logic                  bvalid;
    logic                  bready;
    logic [ID_W-1:0]       bid;
    logic [1:0]            bresp;

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awburst,
        input  wvalid, wlast, wid, wstrb, wdata,
        input  bready,
        output awready, wready, bvalid, bid, bresp
    );

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awburst,
        output wvalid, wlast, wid, wstrb, wdata,
        output bready,
        input  awready, wready, bvalid, bid, bresp
    );
endinterface
`default_nettype wire

// File: rtl/axi_wr_slave_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : axi_wr_slave_mem                                           |
// | Brief    : AXI3 write slave, one outstanding burst, into a word memory|
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module axi_wr_slave_mem #(
    parameter int unsigned        DATA_W    = 32,
    parameter int unsigned        ADDR_W    = 32,
    parameter int unsigned        ID_W      = 4,
    parameter int unsigned        MEM_DEPTH = 256,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    axi_wr_slave_mem_if.slave             bus,
    input  logic [$clog2(MEM_DEPTH)-1:0]  dbg_addr,
    output logic [DATA_W-1:0]             dbg_rdata
);
    localparam int unsigned       c_strb_w   = DATA_W / 8;
    localparam int unsigned       c_lsb      = $clog2(c_strb_w);
    localparam int unsigned       c_idx_w    = $clog2(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] c_depth    = ADDR_W'(MEM_DEPTH);
    localparam logic [2:0]        c_max_size = 3'(c_lsb);
    localparam logic [1:0]        c_fixed    = 2'b00;
    localparam logic [1:0]        c_incr     = 2'b01;
    localparam logic [1:0]        c_wrap     = 2'b10;
    localparam logic [1:0]        c_rsvd     = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          len_q, len_d;
    logic [2:0]          size_q, size_d;
    logic [1:0]          burst_q, burst_d;
    logic [3:0]          beat_q, beat_d;
    logic                decerr_q, decerr_d;
    logic                slverr_q, slverr_d;
    logic                supp_q, supp_d;
    logic                awready_q, awready_d;
    logic                wready_q, wready_d;
    logic                bvalid_q, bvalid_d;
    logic [ID_W-1:0]     bid_q, bid_d;
    logic [1:0]          bresp_q, bresp_d;
    logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;
    logic [DATA_W-1:0]   mem_q [MEM_DEPTH];

    logic [ADDR_W-1:0]   aw_sz;
    logic                aw_supp;
    logic [ADDR_W-1:0]   sz;
    logic [ADDR_W-1:0]   wrap_mask;
    logic [ADDR_W-1:0]   next_addr;
    logic [ADDR_W-1:0]   addr_off;
    logic                addr_borrow;
    logic [ADDR_W-1:0]   word_idx;
    logic                beat_decerr;
    logic [c_idx_w-1:0]  mem_idx;
    logic                mem_we;
    logic                beat_end;

    // Whole-burst suppression is decided once from the AW fields.
    always_comb begin
        aw_sz   = ADDR_W'(1) << bus.awsize;
        aw_supp = (bus.awburst == c_rsvd) ||
                  (bus.awsize > c_max_size) ||
                  ((bus.awburst == c_wrap) &&
                   (!(bus.awlen inside {4'd1, 4'd3, 4'd7, 4'd15}) ||
                    ((bus.awaddr & (aw_sz - ADDR_W'(1))) != '0)));
    end

    // Wrap boundary is a power of two for every burst that can actually write.
    always_comb begin
        sz        = ADDR_W'(1) << size_q;
        wrap_mask = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
        case (burst_q)
            c_incr:  next_addr = (addr_q + sz) & ~(sz - ADDR_W'(1));
            c_wrap:  next_addr = (addr_q & ~wrap_mask) | ((addr_q + sz) & wrap_mask);
            c_fixed: next_addr = addr_q;
            default: next_addr = addr_q;
        endcase
        {addr_borrow, addr_off} = {1'b0, addr_q} - {1'b0, BASE_ADDR};
        word_idx    = addr_off >> c_lsb;
        beat_decerr = addr_borrow || (word_idx >= c_depth);
        mem_idx     = word_idx[c_idx_w-1:0];
        dbg_rdata_d = mem_q[dbg_addr];
    end

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        addr_d   = addr_q;
        len_d    = len_q;
        size_d   = size_q;
        burst_d  = burst_q;
        beat_d   = beat_q;
        decerr_d = decerr_q;
        slverr_d = slverr_q;
        supp_d   = supp_q;
        bid_d    = bid_q;
        bresp_d  = bresp_q;
        mem_we   = 1'b0;
        beat_end = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.awvalid && awready_q) begin
                    id_d     = bus.awid;
                    addr_d   = bus.awaddr;
                    len_d    = bus.awlen;
                    size_d   = bus.awsize;
                    burst_d  = bus.awburst;
                    beat_d   = 4'd0;
                    decerr_d = 1'b0;
                    supp_d   = aw_supp;
                    slverr_d = aw_supp;
                    state_d  = S_DATA;
                end
            end
            S_DATA: begin
                if (bus.wvalid && wready_q) begin
                    mem_we   = !supp_q && !beat_decerr;
                    beat_end = bus.wlast || (beat_q == len_q);
                    decerr_d = decerr_q || beat_decerr;
                    slverr_d = slverr_q || (bus.wid != id_q) ||
                               (bus.wlast && (beat_q != len_q)) ||
                               (!bus.wlast && (beat_q == len_q));
                    addr_d   = next_addr;
                    beat_d   = beat_q + 4'd1;
                    if (beat_end) begin
                        state_d = S_RESP;
                        bid_d   = id_q;
                        bresp_d = decerr_d ? 2'b11 : (slverr_d ? 2'b10 : 2'b00);
                    end
                end
            end
            S_RESP: begin
                if (bus.bready && bvalid_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        awready_d = (state_d == S_IDLE);
        wready_d  = (state_d == S_DATA);
        bvalid_d  = (state_d == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            beat_q      <= '0;
            decerr_q    <= 1'b0;
            slverr_q    <= 1'b0;
            supp_q      <= 1'b0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bid_q       <= '0;
            bresp_q     <= 2'b00;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            beat_q      <= beat_d;
            decerr_q    <= decerr_d;
            slverr_q    <= slverr_d;
            supp_q      <= supp_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            bid_q       <= bid_d;
            bresp_q     <= bresp_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    // Storage is never reset; a beat landing on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            for (int n = 0; n < int'(c_strb_w); n++) begin
                if (bus.wstrb[n]) begin
                    mem_q[mem_idx][8*n +: 8] <= bus.wdata[8*n +: 8];
                end
            end
        end
    end

    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bid     = bid_q;
    assign bus.bresp   = bresp_q;
    assign dbg_rdata   = dbg_rdata_q;
endmodule
`default_nettype wire

// File: tb/tb_axi_wr_slave_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_axi_wr_slave_mem                                        |
// | Brief    : Randomised bench for axi_wr_slave_mem with a burst-level   |
// |            memory/response model                                     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_axi_wr_slave_mem;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned ID_W      = 4;
    localparam int unsigned MEM_DEPTH = 64;
    localparam logic [31:0] BASE_ADDR = 32'h0000_1000;
    localparam int unsigned IDX_W     = $clog2(MEM_DEPTH);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [IDX_W-1:0]  dbg_addr = '0;
    logic [DATA_W-1:0] dbg_rdata;

    axi_wr_slave_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

    axi_wr_slave_mem #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W),
        .MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE_ADDR)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic        chk_en   = 1'b0;
    logic [31:0] exp_dbg  = '0;
    logic [31:0] model_mem [MEM_DEPTH];
    logic [31:0] bdata [16];
    logic [3:0]  bstrb [16];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // Backdoor port shows the model as of the previous edge (zero while in reset).
    always @(posedge clk) exp_dbg <= rst ? model_mem[dbg_addr] : 32'h0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("dbg_rdata", dbg_rdata, exp_dbg);
            chk("phase_excl", ((32'(bus.awready) + 32'(bus.wready) + 32'(bus.bvalid)) <= 1), 1);
        end
        dbg_addr = IDX_W'($urandom_range(0, MEM_DEPTH - 1));
    end

    function automatic bit oob(input longint unsigned a);
        return (a < BASE_ADDR) || (((a - BASE_ADDR) / 4) >= MEM_DEPTH);
    endfunction

    task automatic do_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int wlast_at,
                            input int bad_wid_at, input bit early_w, input int bdelay,
                            input int rst_after, output logic [1:0] got_bresp);
        longint unsigned a, sz, bnd, base;
        longint unsigned baddr [16];
        int nb, n, idx;
        bit supp, slv, dec, early, late;
        logic [1:0]  exp_resp;
        logic [31:0] w;
        got_bresp = 2'bxx;
        sz    = longint'(1) << size;
        early = (wlast_at >= 0) && (wlast_at < int'(len));
        late  = (wlast_at < 0) || (wlast_at > int'(len));
        nb    = early ? wlast_at + 1 : int'(len) + 1;
        supp  = (burst == 2'b11) || (sz > 4) ||
                ((burst == 2'b10) && (!(len inside {4'd1, 4'd3, 4'd7, 4'd15}) || (addr % sz != 0)));
        slv   = supp || early || late || ((bad_wid_at >= 0) && (bad_wid_at < nb));
        a = addr; dec = 0;
        for (int k = 0; k < nb; k++) begin
            baddr[k] = a;
            if (oob(a)) dec = 1;
            if (burst == 2'b01) a = (a / sz + 1) * sz;
            else if (burst == 2'b10) begin
                bnd  = (longint'(len) + 1) * sz;
                base = (a / bnd) * bnd;
                a    = base + (a + sz) % bnd;
            end
        end
        exp_resp = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);

        @(negedge clk);
        bus.awvalid = 1'b1; bus.awid = id; bus.awaddr = addr;
        bus.awlen = len; bus.awsize = size; bus.awburst = burst;
        if (early_w) begin
            bus.wvalid = 1'b1; bus.wdata = bdata[0]; bus.wstrb = bstrb[0];
            bus.wid = (bad_wid_at == 0) ? id ^ 4'h1 : id; bus.wlast = (wlast_at == 0);
        end
        n = 0;
        while (!bus.awready && n < 20) begin
            if (early_w) chk("w_ignored_idle", bus.wready, 0);
            @(negedge clk); n++;
        end
        if (n == 20) begin
            chk("aw_timeout", 0, 1);
            bus.awvalid = 1'b0; bus.wvalid = 1'b0;
            return;
        end
        if (early_w) chk("w_ignored_idle", bus.wready, 0);
        @(negedge clk);
        bus.awvalid = 1'b0;

        for (int k = 0; k < nb; k++) begin
            if (k == rst_after) begin
                bus.wvalid = 1'b0; rst = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    chk("rst_awready", bus.awready, 0); chk("rst_wready", bus.wready, 0);
                    chk("rst_bvalid", bus.bvalid, 0); chk("rst_bid", bus.bid, 0);
                    chk("rst_bresp", bus.bresp, 0);
                end
                rst = 1'b1;
                @(negedge clk);
                chk("awready_after_rst", bus.awready, 1);
                repeat (3) begin chk("no_b_after_rst", bus.bvalid, 0); @(negedge clk); end
                return;
            end
            if (!(early_w && k == 0) && $urandom_range(0, 3) == 0) begin
                bus.wvalid = 1'b0;
                repeat ($urandom_range(1, 2)) begin
                    @(negedge clk);
                    chk("wready_gap", bus.wready, 1);
                end
            end
            bus.wvalid = 1'b1; bus.wdata = bdata[k]; bus.wstrb = bstrb[k];
            bus.wid = (k == bad_wid_at) ? id ^ 4'h1 : id; bus.wlast = (k == wlast_at);
            chk("wready_beat", bus.wready, 1);
            chk("awready_in_data", bus.awready, 0);
            @(posedge clk);
            if (!supp && !oob(baddr[k])) begin
                idx = int'((baddr[k] - BASE_ADDR) / 4);
                w = model_mem[idx];
                for (int l = 0; l < 4; l++) if (bstrb[k][l]) w[8*l +: 8] = bdata[k][8*l +: 8];
                model_mem[idx] <= w;
            end
            @(negedge clk);
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;

        chk("bvalid", bus.bvalid, 1);
        chk("bid", bus.bid, id);
        chk("bresp", bus.bresp, exp_resp);
        chk("wready_in_resp", bus.wready, 0);
        got_bresp = bus.bresp;
        for (int d = 0; d < bdelay; d++) begin
            @(negedge clk);
            chk("bvalid_hold", bus.bvalid, 1); chk("bid_hold", bus.bid, id);
            chk("bresp_hold", bus.bresp, exp_resp); chk("awready_in_resp", bus.awready, 0);
        end
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        chk("bvalid_clear", bus.bvalid, 0);
        chk("awready_after_b", bus.awready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  r;
        logic [3:0]  id, len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [31:0] addr;
        int wl, bad;
        bus.awvalid = 0; bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0;
        bus.awburst = 0; bus.wvalid = 0; bus.wlast = 0; bus.wid = 0; bus.wstrb = 0;
        bus.wdata = 0; bus.bready = 0;

        repeat (3) @(negedge clk);
        chk("reset_awready", bus.awready, 0); chk("reset_wready", bus.wready, 0);
        chk("reset_bvalid", bus.bvalid, 0); chk("reset_bid", bus.bid, 0);
        chk("reset_bresp", bus.bresp, 0); chk("reset_dbg", dbg_rdata, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("awready_out_of_reset", bus.awready, 1);

        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 16; k++) begin bdata[k] = $urandom; bstrb[k] = 4'hF; end
            do_burst(4'(b), BASE_ADDR + 32'(64 * b), 4'd15, 3'd2, 2'b01, 15, -1, 0, 0, -1, r);
        end
        @(negedge clk);
        chk_en = 1'b1;

        for (int k = 0; k < 4; k++) begin bdata[k] = 32'hA0 + 32'(k); bstrb[k] = 4'hF; end
        do_burst(4'd5, BASE_ADDR + 32'h10, 4'd3, 3'd2, 2'b01, 3, -1, 1, 0, -1, r);
        chk("incr_bresp", r, 2'b00);
        for (int k = 0; k < 4; k++) chk("incr_word", model_mem[4 + k], 32'hA0 + 32'(k));

        for (int k = 0; k < 4; k++) bdata[k] = 32'hB0 + 32'(k);
        do_burst(4'd2, BASE_ADDR + 32'h08, 4'd3, 3'd2, 2'b10, 3, -1, 0, 1, -1, r);
        chk("wrap_bresp", r, 2'b00);
        chk("wrap_w2", model_mem[2], 32'hB0); chk("wrap_w3", model_mem[3], 32'hB1);
        chk("wrap_w0", model_mem[0], 32'hB2); chk("wrap_w1", model_mem[1], 32'hB3);

        bdata[0] = 32'h0;
        do_burst(4'd1, BASE_ADDR, 4'd0, 3'd2, 2'b01, 0, -1, 0, 0, -1, r);
        bdata[0] = 32'hDDCC_BBAA; bstrb[0] = 4'b0101;
        do_burst(4'd1, BASE_ADDR, 4'd0, 3'd2, 2'b01, 0, -1, 0, 0, -1, r);
        chk("strobe_word", model_mem[0], 32'h00CC_00AA);

        for (int k = 0; k < 4; k++) begin bdata[k] = 32'hC0 + 32'(k); bstrb[k] = 4'hF; end
        do_burst(4'd3, BASE_ADDR + 32'h20, 4'd3, 3'd2, 2'b01, 1, -1, 0, 0, -1, r);
        chk("early_wlast_bresp", r, 2'b10);
        chk("early_w8", model_mem[8], 32'hC0); chk("early_w9", model_mem[9], 32'hC1);

        bdata[0] = 32'hD0; bdata[1] = 32'hD1;
        do_burst(4'd4, BASE_ADDR + 32'(MEM_DEPTH * 4) - 32'd4, 4'd1, 3'd2, 2'b01, 1, -1, 0, 0, -1, r);
        chk("top_bresp", r, 2'b11);
        chk("top_word", model_mem[MEM_DEPTH - 1], 32'hD0);

        do_burst(4'd6, BASE_ADDR + 32'h30, 4'd1, 3'd2, 2'b01, 1, 0, 0, 5, -1, r);
        chk("wid_bresp", r, 2'b10);

        for (int k = 0; k < 8; k++) bdata[k] = 32'hE0 + 32'(k);
        do_burst(4'd7, BASE_ADDR + 32'h40, 4'd7, 3'd2, 2'b01, 7, -1, 0, 0, 2, r);
        chk("rst_w16", model_mem[16], 32'hE0); chk("rst_w17", model_mem[17], 32'hE1);

        for (int t = 0; t < 150; t++) begin
            id = 4'($urandom); len = 4'($urandom); size = 3'($urandom_range(0, 2));
            burst = 2'($urandom_range(0, 2)); addr = BASE_ADDR + 32'($urandom_range(0, 255));
            wl = int'(len); bad = -1;
            for (int k = 0; k < 16; k++) begin bdata[k] = $urandom; bstrb[k] = 4'($urandom); end
            case ($urandom_range(0, 9))
                0: size = 3'($urandom_range(3, 7));
                1: begin burst = 2'b11; addr = BASE_ADDR + 32'($urandom_range(0, 127)); end
                2: wl = $urandom_range(0, int'(len));
                3: wl = -1;
                4: bad = $urandom_range(0, int'(len));
                5: addr = BASE_ADDR - 32'(4 * $urandom_range(1, 8));
                6: begin burst = 2'b01; addr = BASE_ADDR + 32'h100 - 32'(4 * $urandom_range(0, 4)); end
                default: ;
            endcase
            if (burst == 2'b10) begin
                if ($urandom_range(0, 3) != 0) len = 4'((1 << $urandom_range(1, 4)) - 1);
                if (wl >= 0 && wl > int'(len)) wl = int'(len);
                if (!(len inside {4'd1, 4'd3, 4'd7, 4'd15})) begin
                    size = 3'($urandom_range(0, 2));
                    addr = BASE_ADDR + 32'h40 + 32'($urandom_range(0, 127));
                end else if ($urandom_range(0, 3) != 0) begin
                    addr = addr & ~((32'd1 << size) - 32'd1);
                end
            end
            if (bad > int'(len)) bad = -1;
            do_burst(id, addr, len, size, burst, wl, bad, ($urandom_range(0, 3) == 0),
                     $urandom_range(0, 3), -1, r);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
